// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe; master = operand source and result sink, slave = ALU.
// The Overflow signal exists only when ALU_OVF_EN is defined.
interface alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALU_Sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALU_Out;
  logic             CarryOut;
  logic             Zero;
  logic             DivByZero;
`ifdef ALU_OVF_EN
  logic             Overflow;

  modport master (
    output in_valid, A, B, ALU_Sel, out_ready,
    input  in_ready, out_valid, ALU_Out, CarryOut, Zero, DivByZero, Overflow
  );
  modport slave (
    input  in_valid, A, B, ALU_Sel, out_ready,
    output in_ready, out_valid, ALU_Out, CarryOut, Zero, DivByZero, Overflow
  );
`else
  modport master (
    output in_valid, A, B, ALU_Sel, out_ready,
    input  in_ready, out_valid, ALU_Out, CarryOut, Zero, DivByZero
  );
  modport slave (
    input  in_valid, A, B, ALU_Sel, out_ready,
    output in_ready, out_valid, ALU_Out, CarryOut, Zero, DivByZero
  );
`endif
endinterface

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle ops load the result register directly, DIV runs a
// WIDTH-step restoring divider. Define ALU_OVF_EN to add the signed Overflow flag.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input logic       clock,
  input logic       reset,
  alu_pipe_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IT = CW'(WIDTH - 1);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_DIV  = 1'b1;
  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_MUL = 4'b0010, OP_DIV = 4'b0011;
  localparam logic [3:0] OP_SHL = 4'b0100, OP_SHR = 4'b0101, OP_ROL = 4'b0110, OP_ROR = 4'b0111;
  localparam logic [3:0] OP_AND = 4'b1000, OP_OR = 4'b1001, OP_XOR = 4'b1010, OP_NOR = 4'b1011;
  localparam logic [3:0] OP_NAND = 4'b1100, OP_XNOR = 4'b1101, OP_GT = 4'b1110, OP_EQ = 4'b1111;

  logic [0:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   alu_out_q, alu_out_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH:0]     sum_s, dif_s, rem_sh_s, trial_s;
  logic [2*WIDTH-1:0] prod_s, acc_step_s;
  logic [WIDTH-1:0]   op_out_s, rem_new_s;
  logic               op_carry_s, qbit_s, in_ready_s, accept_s;

  assign sum_s      = {1'b0, bus.A} + {1'b0, bus.B};
  assign dif_s      = {1'b0, bus.A} - {1'b0, bus.B};
  assign prod_s     = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};
  assign in_ready_s = !reset && (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept_s   = bus.in_valid && in_ready_s;

  always_comb begin
    op_out_s   = '0;
    op_carry_s = 1'b0;
    case (bus.ALU_Sel)
      OP_ADD:  begin op_out_s = sum_s[WIDTH-1:0]; op_carry_s = sum_s[WIDTH]; end
      OP_SUB:  begin op_out_s = dif_s[WIDTH-1:0]; op_carry_s = dif_s[WIDTH]; end
      OP_MUL:  begin op_out_s = prod_s[WIDTH-1:0]; op_carry_s = |prod_s[2*WIDTH-1:WIDTH]; end
      OP_DIV:  begin op_out_s = '1; op_carry_s = 1'b1; end
      OP_SHL:  begin op_out_s = {bus.A[WIDTH-2:0], 1'b0}; op_carry_s = bus.A[WIDTH-1]; end
      OP_SHR:  begin op_out_s = {1'b0, bus.A[WIDTH-1:1]}; op_carry_s = bus.A[0]; end
      OP_ROL:  op_out_s = {bus.A[WIDTH-2:0], bus.A[WIDTH-1]};
      OP_ROR:  op_out_s = {bus.A[0], bus.A[WIDTH-1:1]};
      OP_AND:  op_out_s = bus.A & bus.B;
      OP_OR:   op_out_s = bus.A | bus.B;
      OP_XOR:  op_out_s = bus.A ^ bus.B;
      OP_NOR:  op_out_s = ~(bus.A | bus.B);
      OP_NAND: op_out_s = ~(bus.A & bus.B);
      OP_XNOR: op_out_s = ~(bus.A ^ bus.B);
      OP_GT:   op_out_s = {{(WIDTH-1){1'b0}}, (bus.A > bus.B)};
      OP_EQ:   op_out_s = {{(WIDTH-1){1'b0}}, (bus.A == bus.B)};
      default: op_out_s = '0;
    endcase
  end

  // acc holds {remainder, dividend/quotient}; each step shifts one dividend bit into the remainder
  always_comb begin
    rem_sh_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    trial_s  = rem_sh_s - {1'b0, dvs_q};
    if (!trial_s[WIDTH]) begin
      rem_new_s = trial_s[WIDTH-1:0];
      qbit_s    = 1'b1;
    end else begin
      rem_new_s = rem_sh_s[WIDTH-1:0];
      qbit_s    = 1'b0;
    end
    acc_step_s = {rem_new_s, acc_q[WIDTH-2:0], qbit_s};
  end

`ifdef ALU_OVF_EN
  logic op_ovf_s, ovf_q, ovf_d;

  always_comb begin
    if (bus.ALU_Sel == OP_ADD) begin
      op_ovf_s = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum_s[WIDTH-1] != bus.A[WIDTH-1]);
    end else if (bus.ALU_Sel == OP_SUB) begin
      op_ovf_s = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (dif_s[WIDTH-1] != bus.A[WIDTH-1]);
    end else begin
      op_ovf_s = 1'b0;
    end
  end

  assign bus.Overflow = ovf_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    dvs_d     = dvs_q;
    alu_out_d = alu_out_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    dbz_d     = dbz_q;
`ifdef ALU_OVF_EN
    ovf_d     = ovf_q;
`endif
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (accept_s && (bus.ALU_Sel == OP_DIV) && (bus.B != '0)) begin
          state_d = ST_DIV;
          cnt_d   = '0;
          acc_d   = {{WIDTH{1'b0}}, bus.A};
          dvs_d   = bus.B;
        end else if (accept_s) begin
          out_valid_d = 1'b1;
          alu_out_d   = op_out_s;
          carry_d     = op_carry_s;
          zero_d      = (op_out_s == '0);
          dbz_d       = (bus.ALU_Sel == OP_DIV);
`ifdef ALU_OVF_EN
          ovf_d       = op_ovf_s;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DIV: begin
        acc_d = acc_step_s;
        if (cnt_q == LAST_IT) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b1;
          alu_out_d   = acc_step_s[WIDTH-1:0];
          carry_d     = |acc_step_s[2*WIDTH-1:WIDTH];
          zero_d      = (acc_step_s[WIDTH-1:0] == '0);
          dbz_d       = 1'b0;
`ifdef ALU_OVF_EN
          ovf_d       = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1'b1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      dvs_q       <= '0;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
`ifdef ALU_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      dvs_q       <= dvs_d;
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      dbz_q       <= dbz_d;
`ifdef ALU_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.ALU_Out   = alu_out_q;
  assign bus.CarryOut  = carry_q;
  assign bus.Zero      = zero_q;
  assign bus.DivByZero = dbz_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Randomised and directed bench for alu_pipe (WIDTH=8) with an arithmetic reference
// model and an in-order result scoreboard.
module tb_alu_pipe;
  localparam int W = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  alu_pipe_if #(.WIDTH(W)) bus();
  alu_pipe #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_pops   = 0;
  logic [10:0] exp_q[$];
  bit          s_in_ready, s_out_valid, s_carry, s_zero, s_dbz;
  logic [7:0]  s_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {DivByZero, Zero, CarryOut, ALU_Out} from plain integer arithmetic
  function automatic logic [10:0] model(input int a, input int b, input int sel);
    int r;
    bit c, dz;
    c = 1'b0;
    dz = 1'b0;
    case (sel)
      0:  begin r = a + b; c = (r > 255); end
      1:  begin r = a - b; c = (a < b); end
      2:  begin r = a * b; c = (r > 255); end
      3:  if (b == 0) begin r = 255; c = 1'b1; dz = 1'b1; end
          else begin r = a / b; c = ((a % b) != 0); end
      4:  begin r = a * 2; c = (a >= 128); end
      5:  begin r = a / 2; c = ((a % 2) == 1); end
      6:  r = a * 2 + a / 128;
      7:  r = a / 2 + (a % 2) * 128;
      8:  r = a & b;
      9:  r = a | b;
      10: r = a ^ b;
      11: r = ~(a | b);
      12: r = ~(a & b);
      13: r = ~(a ^ b);
      14: r = (a > b) ? 1 : 0;
      default: r = (a == b) ? 1 : 0;
    endcase
    r = r & 255;
    return {dz, (r == 0), c, 8'(r)};
  endfunction

  // One clock: sample just after the falling edge, score handshakes that the next rising edge takes
  task automatic tick();
    logic [10:0] got;
    #1;
    s_in_ready  = bus.in_ready;
    s_out_valid = bus.out_valid;
    s_out       = bus.ALU_Out;
    s_carry     = bus.CarryOut;
    s_zero      = bus.Zero;
    s_dbz       = bus.DivByZero;
    if (s_out_valid && bus.out_ready) begin
      got = {s_dbz, s_zero, s_carry, s_out};
      check("sb_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("result", got, exp_q.pop_front());
      n_pops++;
    end
    if (bus.in_valid && s_in_ready)
      exp_q.push_back(model(int'(bus.A), int'(bus.B), int'(bus.ALU_Sel)));
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive(input bit v, input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b);
    bus.in_valid = v;
    bus.ALU_Sel  = sel;
    bus.A        = a;
    bus.B        = b;
  endtask

  task automatic wait_result(output int lat, output bit saw_ready);
    lat = 0;
    saw_ready = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      lat++;
      if (s_out_valid) break;
      if (s_in_ready) saw_ready = 1'b1;
    end
  endtask

  initial begin
    int lat, p0;
    bit flag;
    logic [3:0] ops[16];
    logic [7:0] a, b;
    ops = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
            4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0};
    reset = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 4'd0, 8'h12, 8'h34);
    @(negedge clock);

    repeat (2) begin
      tick();
      check("rst_in_ready", s_in_ready, 0);
    end
    check("rst_out_valid", s_out_valid, 0);
    check("rst_outputs", {s_dbz, s_zero, s_carry, s_out}, 0);

    reset = 1'b0;
    drive(1'b1, 4'd0, 8'hFF, 8'h01);
    tick();
    check("first_accept", s_in_ready, 1);
    drive(1'b1, 4'd1, 8'h03, 8'h05);
    tick();
    check("add_valid", s_out_valid, 1);
    check("add_flags", {s_zero, s_carry, s_out}, {1'b1, 1'b1, 8'h00});
    drive(1'b0, 4'd0, 8'h00, 8'h00);
    tick();
    check("sub_result", {s_carry, s_out}, {1'b1, 8'hFE});

    drive(1'b1, 4'd3, 8'h64, 8'h07);
    tick();
    check("div_accept", s_in_ready, 1);
    wait_result(lat, flag);
    check("div_latency", lat, 9);
    check("div_busy_ready", flag, 0);
    check("div_result", {s_carry, s_out}, {1'b1, 8'h0E});

    drive(1'b1, 4'd3, 8'h10, 8'h00);
    tick();
    wait_result(lat, flag);
    check("div0_latency", lat, 1);
    check("div0_result", {s_dbz, s_carry, s_out}, {1'b1, 1'b1, 8'hFF});

    bus.out_ready = 1'b0;
    drive(1'b1, 4'd2, 8'h10, 8'h10);
    tick();
    drive(1'b1, 4'd10, 8'h5A, 8'hA5);
    repeat (3) begin
      tick();
      check("bp_valid", s_out_valid, 1);
      check("bp_hold", {s_zero, s_carry, s_out}, {1'b1, 1'b1, 8'h00});
      check("bp_in_ready", s_in_ready, 0);
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_release_accept", s_in_ready, 1);
    drive(1'b0, 4'd0, 8'h00, 8'h00);
    tick();
    check("bp_next_result", s_out, 8'hFF);

    p0 = n_pops;
    flag = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, ops[i], 8'($urandom), 8'($urandom));
      tick();
      if (!s_in_ready) flag = 1'b1;
      if (i > 0 && !s_out_valid) flag = 1'b1;
    end
    drive(1'b0, 4'd0, 8'h00, 8'h00);
    tick();
    check("tput_no_stall", flag, 0);
    check("tput_results", n_pops - p0, 16);

    drive(1'b1, 4'd3, 8'hC8, 8'h03);
    tick();
    drive(1'b0, 4'd0, 8'h00, 8'h00);
    repeat (3) tick();
    reset = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    flag = 1'b0;
    repeat (12) begin
      tick();
      if (s_out_valid) flag = 1'b1;
    end
    check("abort_no_result", flag, 0);
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(1, 255));
    drive(1'b1, 4'd3, a, b);
    tick();
    wait_result(lat, flag);
    check("div2_latency", lat, 9);
    check("div2_quotient", s_out, 32'(a / b));

    for (int i = 0; i < 400; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), a, b);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drive(1'b0, 4'd0, 8'h00, 8'h00);
    bus.out_ready = 1'b1;
    repeat (20) tick();
    check("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
